// File: rtl/cache_rd_arbiter.sv
// Read-port arbiter between icache (req 0) and dcache (req 1) refills on one AXI AR/R channel.
// Define ARB_RR_EN for round-robin arbitration; the default is fixed priority with dcache winning ties.
module cache_rd_arbiter #(
  parameter int         LINE_WORDS = 4,
  parameter logic [3:0] ID_I       = 4'd0,
  parameter logic [3:0] ID_D       = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rd_req,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,
  input  logic        d_rd_req,
  input  logic [2:0]  d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic [3:0]  rid,
  output logic        rready
);
  localparam int         NREQ      = 2;
  localparam int         CW        = $clog2(LINE_WORDS) + 1;
  localparam logic [7:0] LINE_LEN  = 8'(LINE_WORDS - 1);
  localparam logic [2:0] TYPE_LINE = 3'b100;

  typedef enum logic { AR_IDLE, AR_BUSY } ar_state_e;

  ar_state_e               st_q, st_d;
  logic                    arvalid_q, arvalid_d;
  logic [31:0]             araddr_q, araddr_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [3:0]              arid_q, arid_d;
  logic                    rready_q;
  logic [NREQ-1:0]         busy_q, busy_d;
  logic [NREQ-1:0][CW-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]         req, elig, hit, gnt;
  logic [NREQ-1:0][2:0]    req_type;
  logic [NREQ-1:0][31:0]   req_addr;
  logic [NREQ-1:0][3:0]    req_id;
  logic                    gnt_any, gnt_sel;

  assign req      = {d_rd_req, i_rd_req};
  assign req_type = {d_rd_type, i_rd_type};
  assign req_addr = {d_rd_addr, i_rd_addr};
  assign req_id   = {ID_D, ID_I};

  // Eligibility looks only at registered busy, so an rlast beat never races a regrant.
  assign elig    = req & ~busy_q;
  assign gnt_any = (st_q == AR_IDLE) && (|elig) && !reset;

`ifdef ARB_RR_EN
  logic ptr_q;
  assign gnt_sel = (&elig) ? ptr_q : elig[1];
  always_ff @(posedge clk) begin
    if (reset)        ptr_q <= 1'b0;
    else if (gnt_any) ptr_q <= ~gnt_sel;
  end
`else
  assign gnt_sel = elig[1];
`endif

  assign gnt      = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign i_rd_rdy = gnt[0];
  assign d_rd_rdy = gnt[1];

  always_comb begin
    st_d      = st_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arid_d    = arid_q;
    case (st_q)
      AR_IDLE: if (gnt_any) begin
        araddr_d  = req_addr[gnt_sel];
        arid_d    = req_id[gnt_sel];
        arlen_d   = (req_type[gnt_sel] == TYPE_LINE) ? LINE_LEN : 8'd0;
        arvalid_d = 1'b1;
        st_d      = AR_BUSY;
      end
      AR_BUSY: if (arready) begin
        arvalid_d = 1'b0;
        st_d      = AR_IDLE;
      end
      default: st_d = AR_IDLE;
    endcase
  end

  // Beats are steered on rid alone; only an owner with a transaction in flight counts them.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    for (int g = 0; g < NREQ; g++) begin
      hit[g] = rvalid && rready_q && (rid == req_id[g]);
      if (hit[g] && busy_q[g]) begin
        if (rlast) begin
          busy_d[g] = 1'b0;
          cnt_d[g]  = '0;
        end else begin
          cnt_d[g]  = cnt_q[g] + CW'(1);
        end
      end
      if (gnt[g]) busy_d[g] = 1'b1;
    end
  end

  assign i_ret_valid = hit[0];
  assign i_ret_last  = hit[0] & rlast;
  assign i_ret_data  = hit[0] ? rdata : '0;
  assign d_ret_valid = hit[1];
  assign d_ret_last  = hit[1] & rlast;
  assign d_ret_data  = hit[1] ? rdata : '0;

  assign arvalid = arvalid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arid    = arid_q;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign rready  = rready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= AR_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arid_q    <= '0;
      rready_q  <= 1'b0;
      busy_q    <= '0;
      cnt_q     <= '0;
    end else begin
      st_q      <= st_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arid_q    <= arid_d;
      rready_q  <= 1'b1;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized scoreboard bench for cache_rd_arbiter; follows ARB_RR_EN when the design is built with it.
module tb_cache_rd_arbiter;
  localparam int         LW  = 4;
  localparam logic [3:0] IDI = 4'd0;
  localparam logic [3:0] IDD = 4'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_req = 1'b0, d_req = 1'b0;
  logic [2:0]  i_type = '0, d_type = '0;
  logic [31:0] i_addr = '0, d_addr = '0;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic [3:0]  rid = '0;

  logic        i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data, araddr;
  logic        arvalid, rready;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;

  cache_rd_arbiter #(.LINE_WORDS(LW), .ID_I(IDI), .ID_D(IDD)) dut (
    .clk(clk), .reset(rst),
    .i_rd_req(i_req), .i_rd_type(i_type), .i_rd_addr(i_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_req), .d_rd_type(d_type), .d_rd_addr(d_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arid(arid), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rid(rid), .rready(rready)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [3:0] id; } ar_t;
  typedef struct { logic [31:0] data; logic last; } ret_t;

  ar_t  ar_exp[$];
  ret_t ret_q0[$], ret_q1[$];
  int   n_cmp = 0, n_err = 0;
  logic [1:0] m_busy = '0;
  logic m_infl = 1'b0, m_ptr = 1'b0, rst_prev = 1'b1;
  bit   ar_rand = 1'b0;

  function void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function void flag(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event without expectation at %0t", nm, $time);
  endfunction

  function logic [7:0] exp_len(logic [2:0] t);
    return (t == 3'b100) ? 8'(LW - 1) : 8'd0;
  endfunction

  // Monitor: reference model of grants/AR plus scoreboard pops for returns.
  always @(negedge clk) begin : mon
    ar_t  a;
    ret_t r;
    logic e0, e1, hs;
    int   win;
    if (rst) begin
      if (rst_prev) begin
        chk("rst_ar_ctl", 32'({arvalid, arid, arlen}), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_cache_side", 32'({i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_last, d_ret_valid, d_ret_last}), 32'd0);
      end
      ar_exp.delete(); ret_q0.delete(); ret_q1.delete();
      m_busy = '0; m_infl = 1'b0; m_ptr = 1'b0;
    end else begin
      chk("rready", 32'(rready), 32'(!rst_prev));
      hs = 1'b0;
      chk("arvalid", 32'(arvalid), 32'(ar_exp.size() != 0));
      if (arvalid && ar_exp.size() != 0) begin
        a = ar_exp[0];
        chk("araddr", araddr, a.addr);
        chk("arlen", 32'(arlen), 32'(a.len));
        chk("arid", 32'(arid), 32'(a.id));
        chk("arsize_burst", 32'({arsize, arburst}), 32'({3'b010, 2'b01}));
        if (arready) begin
          a  = ar_exp.pop_front();
          hs = 1'b1;
        end
      end
      e0  = i_req && !m_busy[0];
      e1  = d_req && !m_busy[1];
      win = -1;
      if (!m_infl && (e0 || e1)) begin
`ifdef ARB_RR_EN
        win = (e0 && e1) ? int'(m_ptr) : (e1 ? 1 : 0);
`else
        win = e1 ? 1 : 0;
`endif
      end
      chk("i_rd_rdy", 32'(i_rd_rdy), 32'(win == 0));
      chk("d_rd_rdy", 32'(d_rd_rdy), 32'(win == 1));
      if (win == 0) begin
        a.addr = i_addr; a.len = exp_len(i_type); a.id = IDI;
        ar_exp.push_back(a);
      end else if (win == 1) begin
        a.addr = d_addr; a.len = exp_len(d_type); a.id = IDD;
        ar_exp.push_back(a);
      end
      if (win >= 0) begin
        m_busy[win] = 1'b1;
        m_infl = 1'b1;
        m_ptr  = (win == 0);
      end
      if (hs) m_infl = 1'b0;
      if (i_ret_valid) begin
        if (ret_q0.size() == 0) flag("i_ret_spurious");
        else begin
          r = ret_q0.pop_front();
          chk("i_ret_data", i_ret_data, r.data);
          chk("i_ret_last", 32'(i_ret_last), 32'(r.last));
        end
      end
      if (d_ret_valid) begin
        if (ret_q1.size() == 0) flag("d_ret_spurious");
        else begin
          r = ret_q1.pop_front();
          chk("d_ret_data", d_ret_data, r.data);
          chk("d_ret_last", 32'(d_ret_last), 32'(r.last));
        end
      end
      chk("ret_last_alone", 32'({i_ret_last & !i_ret_valid, d_ret_last & !d_ret_valid}), 32'd0);
      if (rvalid && rlast && !rst_prev) begin
        if (rid == IDI) m_busy[0] = 1'b0;
        if (rid == IDD) m_busy[1] = 1'b0;
      end
    end
    rst_prev = rst;
  end

  // AXI slave: random arready with stall bursts, interleaved R beats, occasional foreign rid.
  initial begin : rdrv
    int   left [2];
    int   stall, pick;
    ret_t r;
    left[0] = 0; left[1] = 0; stall = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        left[0] = 0; left[1] = 0;
      end else if (arvalid && arready) begin
        left[(arid == IDD) ? 1 : 0] = int'(arlen) + 1;
      end
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0; rid = '0; rdata = '0;
      if (!rst && $urandom_range(0, 3) != 0) begin
        pick = -1;
        if ($urandom_range(0, 9) == 0) pick = 2;
        else if (left[0] > 0 && left[1] > 0) pick = int'($urandom_range(0, 1));
        else if (left[0] > 0) pick = 0;
        else if (left[1] > 0) pick = 1;
        if (pick == 2) begin
          rvalid = 1'b1; rid = 4'd9; rdata = $urandom; rlast = 1'($urandom_range(0, 1));
        end else if (pick >= 0) begin
          rvalid = 1'b1; rid = (pick == 1) ? IDD : IDI; rdata = $urandom;
          rlast  = (left[pick] == 1);
          left[pick]--;
          r.data = rdata; r.last = rlast;
          if (pick == 0) ret_q0.push_back(r); else ret_q1.push_back(r);
        end
      end
      if (!ar_rand) arready = 1'b1;
      else if (stall > 0) begin arready = 1'b0; stall--; end
      else if ($urandom_range(0, 9) == 0) begin arready = 1'b0; stall = 4; end
      else arready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic do_req(input int x, input logic [31:0] addr, input logic [2:0] typ, input bit hold);
    int t;
    if (x == 0) begin i_req = 1'b1; i_addr = addr; i_type = typ; end
    else        begin d_req = 1'b1; d_addr = addr; d_type = typ; end
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!((x == 0) ? i_rd_rdy : d_rd_rdy) && t < 400);
    if (t >= 400) flag((x == 0) ? "i_grant_timeout" : "d_grant_timeout");
    @(posedge clk); #1;
    if (!hold) begin
      if (x == 0) i_req = 1'b0; else d_req = 1'b0;
    end
  endtask

  task automatic rand_req(input int x, input int n);
    bit          hold;
    int          gap;
    logic [2:0]  typ;
    logic [31:0] addr;
    hold = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (!hold) begin
        gap = int'($urandom_range(0, 4));
        repeat (gap) begin @(posedge clk); #1; end
      end
      case ($urandom_range(0, 2))
        0:       typ = 3'b010;
        1:       typ = 3'b100;
        default: typ = 3'b001;
      endcase
      addr = $urandom & 32'hffff_fffc;
      hold = (k < n - 1) && ($urandom_range(0, 2) == 0);
      do_req(x, addr, typ, hold);
    end
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    while ((ar_exp.size() != 0 || m_busy != 2'b00 || ret_q0.size() != 0 || ret_q1.size() != 0) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_cycles_ok", 32'(t < 1000), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin : main
    int t, n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Lone dcache line refill.
    do_req(1, 32'h1c00_0040, 3'b100, 1'b0);
    wait_quiet();

    // Simultaneous word requests, twice.
    repeat (2) begin
      fork
        do_req(0, 32'h1c00_0000, 3'b010, 1'b0);
        do_req(1, 32'h0000_1000, 3'b010, 1'b0);
      join
      wait_quiet();
    end

    // Random traffic with AR stalls, held requests, interleaved returns.
    ar_rand = 1'b1;
    fork
      rand_req(0, 40);
      rand_req(1, 40);
    join
    wait_quiet();
    ar_rand = 1'b0;

    // Reset in the middle of an icache line refill.
    do_req(0, 32'h1c00_0100, 3'b100, 1'b0);
    t = 0; n = 0;
    while (n < 2 && t < 200) begin
      @(negedge clk);
      if (i_ret_valid) n++;
      t++;
    end
    chk("midburst_beats_seen", 32'(n), 32'd2);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(0, 32'h1c00_0200, 3'b010, 1'b0);
    wait_quiet();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #400000;
    n_err++;
    $display("FAIL watchdog: run still active at %0t, limit 400000", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/cache_rd_arbiter.md
Name: cache_rd_arbiter

Overview:
- Shares the single AXI-style read-address/read-data port between the instruction-cache refill path (requester 0) and the data-cache refill/uncached-load path (requester 1).
- Accepts cache read requests, issues AR beats with fixed ID per requester, counts returning R beats and steers them to the owning cache.
- Sits between the icache/dcache miss logic and the AXI bridge. Allows up to one outstanding transaction per requester, so two in total.

Parameters:
- LINE_WORDS, 4, words per cache line; sets arlen for line refills (arlen = LINE_WORDS-1).
- ID_I, 4'd0, arid/rid used for requester 0.
- ID_D, 4'd1, arid/rid used for requester 1.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- i_rd_req  input  1  icache read request.
- i_rd_type  input  3  3'b010 = single word, 3'b100 = cache line.
- i_rd_addr  input  32  icache request address.
- i_rd_rdy  output  1  icache request accepted this cycle.
- i_ret_valid  output  1  icache return beat valid.
- i_ret_last  output  1  last icache return beat.
- i_ret_data  output  32  icache return data.
- d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data  same directions/widths as the icache set; dcache side.
- arvalid  output  1  AR valid.
- araddr  output  32  AR address.
- arlen  output  8  beats minus one.
- arsize  output  3  fixed 3'b010.
- arburst  output  2  fixed 2'b01 (INCR).
- arid  output  4  requester ID.
- arready  input  1  AR accepted.
- rvalid  input  1  R beat valid.
- rdata  input  32  R data.
- rlast  input  1  final R beat.
- rid  input  4  R ID.
- rready  output  1  R ready.

Behaviour:
- Reset (clk, synchronous, active-high): arvalid=0, araddr=0, arlen=0, arid=0, rready=0, i_rd_rdy=d_rd_rdy=0, all ret_valid/ret_last=0, outstanding flags and beat counters cleared, AR FSM = AR_IDLE, RR pointer = 0.
- rready = 1 every cycle after reset; caches always sink returns.

AR FSM, two states:
- AR_IDLE: eligible(x) = x_rd_req && !out_busy[x].
  - If any requester is eligible, grant one. Default is fixed priority, dcache over icache.
  - In the grant cycle, assert x_rd_rdy combinationally for exactly one cycle.
  - On the next edge, register araddr = x_rd_addr, arid, and arlen (type 3'b100 -> LINE_WORDS-1, else 0). Set arvalid=1, set out_busy[x], go to AR_BUSY.
- AR_BUSY: hold all AR fields stable while arvalid && !arready. On arvalid && arready, clear arvalid and go to AR_IDLE.
  - No new grant in the cycle arready is seen, so there are at most one AR issue every 2 cycles.

R steering:
- rvalid && rid==ID_I -> i_ret_valid=1, i_ret_data=rdata, i_ret_last=rlast. The rid==ID_D case goes to the d_ outputs the same way.
- Steering is combinational, zero latency.
- Per-requester beat counter increments on each steered beat.
- On the rlast beat: clear out_busy[x] and reset that counter. The requester becomes eligible again the next cycle.
- R beats with an unknown rid are dropped; rready stays 1.

Boundary conditions:
- Both requests in the same cycle: the grant rule decides. The loser holds its request and is granted on the next AR_IDLE.
- A requester with out_busy set is never granted, even if its rd_req is held high.
- R data may arrive for one requester while the AR for the other is stalled; both proceed independently.
- The rlast beat and a new grant to the same requester in the same cycle are not allowed. Eligibility uses the registered out_busy.
- Reset mid-burst discards the rest of the transaction. Later beats arriving after reset are steered but not counted, because out_busy is clear.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit pointer names the preferred requester and flips to the non-granted one after each grant. Simultaneous requests therefore alternate I, D, I, D.
- Undefined: fixed priority, dcache wins every tie, and no pointer register exists.

Test Plan:
- d_rd_req line at 0x1c000040 alone, arready=1 immediately -> d_rd_rdy pulses 1 cycle; next cycle arvalid=1, araddr=0x1c000040, arlen=3, arid=1. Four R beats with rid=1 -> d_ret_valid x4, d_ret_last only on beat 4.
- i_rd_req word at 0x1c000000 and d_rd_req word at 0x00001000 in the same cycle, no ARB_RR_EN -> dcache granted first (arid=1, arlen=0); icache granted after the AR handshake (arid=0).
- Same as above with ARB_RR_EN, pointer 0 at reset -> icache first, then dcache; a repeat of both requests after both complete -> icache first again (pointer flipped twice).
- arready held 0 for 5 cycles -> araddr, arlen and arid stable throughout; no second rd_rdy pulse.
- Interleaved R: icache line beats rid=0 and a dcache word rid=1 mixed -> each beat routed only to its owner, and each requester's ret_last appears only on its own rlast.
- i_rd_req held high after acceptance while R is pending -> no second i_rd_rdy until the cycle after the icache rlast beat.
- Reset asserted during a 4-beat refill -> all outputs return to reset values and out_busy is cleared.
